// File: rtl/mem_responder_256x8_if.sv
// mem_responder_256x8_if: request/completion bus between the datapath and the memory responder
interface mem_responder_256x8_if;
  logic        MFA;
  logic        R_W;
  logic [2:0]  DATA_SIZE;
  logic [31:0] ADDRESS;
  logic [31:0] DATA_IN;
  logic        MOC;
  logic [31:0] DATA_OUT;
  modport master (output MFA, R_W, DATA_SIZE, ADDRESS, DATA_IN, input MOC, DATA_OUT);
  modport slave (input MFA, R_W, DATA_SIZE, ADDRESS, DATA_IN, output MOC, DATA_OUT);
endinterface

// File: rtl/mem_responder_256x8.sv
// mem_responder_256x8: 256-byte big-endian memory responder with programmable wait states
module mem_responder_256x8 #(
  parameter int WAIT_STATES = 2
) (
  input logic CLK,
  input logic RESET,
  mem_responder_256x8_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, RESPOND} state_t;
  state_t state, nxt;
  logic [3:0] wcnt;
  logic rw;
  logic [2:0] size;
  logic [7:0] a, a_in;
  logic [31:0] din, dout, rdata;
  logic [7:0] mem [256];
  logic [7:0] m0, m1, m2, m3;
  logic access, ext, unused_addr;
  assign unused_addr = ^bus.ADDRESS[31:8];
  assign a_in = bus.DATA_SIZE[1] ? {bus.ADDRESS[7:2], 2'b00} :
                bus.DATA_SIZE[0] ? {bus.ADDRESS[7:1], 1'b0} : bus.ADDRESS[7:0];
  always_comb begin
    nxt = state;
    access = 1'b0;
    case (state)
      IDLE: nxt = bus.MFA ? BUSY : IDLE;
      BUSY: begin
        nxt = !bus.MFA ? IDLE : (wcnt == 4'd0) ? RESPOND : BUSY;
        access = bus.MFA && wcnt == 4'd0;
      end
      RESPOND: nxt = bus.MFA ? RESPOND : IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    m0 = mem[a];
    m1 = mem[a + 8'd1];
    m2 = mem[a + 8'd2];
    m3 = mem[a + 8'd3];
    ext = size[2] & m0[7];
    rdata = size[1] ? {m0, m1, m2, m3} : size[0] ? {{16{ext}}, m0, m1} : {{24{ext}}, m0};
  end
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state <= IDLE;
      wcnt <= 4'd0;
      dout <= 32'd0;
    end else begin
      state <= nxt;
      if (state == IDLE && bus.MFA) begin
        wcnt <= 4'(WAIT_STATES);
        rw <= bus.R_W;
        size <= bus.DATA_SIZE;
        a <= a_in;
        din <= bus.DATA_IN;
      end else if (state == BUSY && wcnt != 4'd0) begin
        wcnt <= wcnt - 4'd1;
      end
      if (access && rw) dout <= rdata;
    end
  end
  // memory is deliberately outside reset so its contents survive RESET
  always_ff @(posedge CLK) begin
    if (RESET && access && !rw) begin
      if (size[1]) begin
        mem[a] <= din[31:24];
        mem[a + 8'd1] <= din[23:16];
        mem[a + 8'd2] <= din[15:8];
        mem[a + 8'd3] <= din[7:0];
      end else if (size[0]) begin
        mem[a] <= din[15:8];
        mem[a + 8'd1] <= din[7:0];
      end else begin
        mem[a] <= din[7:0];
      end
    end
  end
  assign bus.MOC = (state == RESPOND);
  assign bus.DATA_OUT = dout;
endmodule

// File: tb/tb_mem_responder_256x8.sv
// tb_mem_responder_256x8: scoreboard bench for the memory responder at WAIT_STATES 2 and 0
module tb_mem_responder_256x8;
  logic CLK = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;
  logic mfa = 1'b0, rw = 1'b0, sel = 1'b0;
  logic [2:0] size = 3'd0;
  logic [31:0] addr = 32'd0, din = 32'd0;
  int checks = 0, errors = 0;
  logic [31:0] exp_q [$];
  localparam logic [2:0] SZ_B = 3'b000, SZ_H = 3'b001, SZ_W = 3'b010, SZ_SB = 3'b100, SZ_SH = 3'b101;
  mem_responder_256x8_if b0 ();
  mem_responder_256x8_if b1 ();
  mem_responder_256x8 #(.WAIT_STATES(2)) dut0 (.CLK(CLK), .RESET(RESET), .bus(b0.slave));
  mem_responder_256x8 #(.WAIT_STATES(0)) dut1 (.CLK(CLK), .RESET(RESET), .bus(b1.slave));
  assign b0.MFA = mfa & ~sel;
  assign b1.MFA = mfa & sel;
  assign b0.R_W = rw;
  assign b1.R_W = rw;
  assign b0.DATA_SIZE = size;
  assign b1.DATA_SIZE = size;
  assign b0.ADDRESS = addr;
  assign b1.ADDRESS = addr;
  assign b0.DATA_IN = din;
  assign b1.DATA_IN = din;
  wire moc = sel ? b1.MOC : b0.MOC;
  wire [31:0] dout = sel ? b1.DATA_OUT : b0.DATA_OUT;

  task automatic txn(input logic s, input logic r, input logic [2:0] sz, input logic [31:0] a,
                     input logic [31:0] d, output logic [31:0] q);
    int n = 0;
    int want = s ? 1 : 3;
    @(negedge CLK);
    sel = s; rw = r; size = sz; addr = a; din = d; mfa = 1'b1;
    do begin @(posedge CLK); #1; n++; end while (!moc && n < 40);
    checks++;
    if (n - 1 !== want) begin errors++; $display("FAIL latency a=%h got %0d want %0d", a, n - 1, want); end
    q = dout;
    @(negedge CLK); mfa = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if (moc !== 1'b0) begin errors++; $display("FAIL moc_fall a=%h got %b want 0", a, moc); end
  endtask

  task automatic wr(input logic s, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] q;
    txn(s, 1'b0, sz, a, d, q);
  endtask

  task automatic rd(input string nm, input logic s, input logic [2:0] sz, input logic [31:0] a,
                    input logic [31:0] e);
    logic [31:0] q, x;
    exp_q.push_back(e);
    txn(s, 1'b1, sz, a, 32'd0, q);
    x = exp_q.pop_front();
    checks++;
    if (q !== x) begin errors++; $display("FAIL %s got %h want %h", nm, q, x); end
  endtask

  task automatic test_reset;
    int n = 0;
    sel = 1'b0; rw = 1'b0; size = SZ_B; addr = 32'h80; din = 32'h11; mfa = 1'b1; RESET = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge CLK); #1;
      checks++;
      if (b0.MOC !== 1'b0) begin errors++; $display("FAIL reset_moc got %b want 0", b0.MOC); end
      checks++;
      if (b0.DATA_OUT !== 32'd0) begin errors++; $display("FAIL reset_dout got %h want 0", b0.DATA_OUT); end
    end
    @(negedge CLK); RESET = 1'b1;
    do begin @(posedge CLK); #1; n++; end while (!moc && n < 40);
    checks++;
    if (n - 1 !== 3) begin errors++; $display("FAIL reset_release_latency got %0d want 3", n - 1); end
    @(negedge CLK); mfa = 1'b0;
    @(posedge CLK); #1;
    rd("reset_write_byte", 1'b0, SZ_B, 32'h80, 32'h11);
  endtask

  task automatic test_word_be;
    wr(1'b0, SZ_W, 32'h10, 32'hDEADBEEF);
    rd("be_byte10", 1'b0, SZ_B, 32'h10, 32'hDE);
    rd("be_byte11", 1'b0, SZ_B, 32'h11, 32'hAD);
    rd("be_byte12", 1'b0, SZ_B, 32'h12, 32'hBE);
    rd("be_byte13", 1'b0, SZ_B, 32'hFFFF_FF13, 32'hEF);
    rd("be_word13", 1'b0, SZ_W, 32'h13, 32'hDEADBEEF);
  endtask

  task automatic test_subword;
    wr(1'b0, SZ_W, 32'h20, 32'h11223344);
    wr(1'b0, SZ_H, 32'h21, 32'hFFFF8001);
    rd("half_u", 1'b0, SZ_H, 32'h20, 32'h00008001);
    rd("half_s", 1'b0, SZ_SH, 32'h21, 32'hFFFF8001);
    rd("byte_s21", 1'b0, SZ_SB, 32'h21, 32'h00000001);
    rd("byte_s20", 1'b0, SZ_SB, 32'h20, 32'hFFFFFF80);
    rd("byte22", 1'b0, SZ_B, 32'h22, 32'h33);
    rd("byte23", 1'b0, SZ_B, 32'h23, 32'h44);
    rd("word20", 1'b0, SZ_W, 32'h20, 32'h80013344);
  endtask

  task automatic test_handshake_hold;
    int n = 0;
    @(negedge CLK);
    sel = 1'b0; rw = 1'b1; size = SZ_W; addr = 32'h10; mfa = 1'b1;
    do begin @(posedge CLK); #1; n++; end while (!moc && n < 40);
    checks++;
    if (n - 1 !== 3) begin errors++; $display("FAIL hold_latency got %0d want 3", n - 1); end
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK); addr = 32'h20; size = SZ_B;
      @(posedge CLK); #1;
      checks++;
      if (moc !== 1'b1 || dout !== 32'hDEADBEEF) begin
        errors++; $display("FAIL hold_stable cyc=%0d got moc=%b dout=%h want 1 deadbeef", i, moc, dout);
      end
    end
    @(negedge CLK); mfa = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if (moc !== 1'b0) begin errors++; $display("FAIL hold_drop got %b want 0", moc); end
    rd("hold_reassert", 1'b0, SZ_W, 32'h20, 32'h80013344);
  endtask

  task automatic test_abort;
    logic bad;
    wr(1'b0, SZ_W, 32'h40, 32'h0BADF00D);
    for (int k = 0; k < 3; k++) begin
      bad = 1'b0;
      @(negedge CLK);
      sel = 1'b0; rw = 1'b0; size = SZ_W; addr = 32'h40; din = 32'h12345678; mfa = 1'b1;
      @(posedge CLK);
      for (int j = 0; j < k; j++) @(posedge CLK);
      @(negedge CLK); mfa = 1'b0;
      for (int j = 0; j < 5; j++) begin @(posedge CLK); #1; if (moc !== 1'b0) bad = 1'b1; end
      checks++;
      if (bad) begin errors++; $display("FAIL abort_moc k=%0d got 1 want 0", k); end
      rd("abort_mem", 1'b0, SZ_W, 32'h40, 32'h0BADF00D);
    end
  endtask

  task automatic test_mid_reset;
    rd("pre_reset_read", 1'b0, SZ_W, 32'h10, 32'hDEADBEEF);
    @(negedge CLK);
    sel = 1'b0; rw = 1'b0; size = SZ_W; addr = 32'h40; din = 32'h12345678; mfa = 1'b1;
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK); RESET = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if (moc !== 1'b0 || dout !== 32'd0) begin
      errors++; $display("FAIL midreset got moc=%b dout=%h want 0 0", moc, dout);
    end
    @(negedge CLK); RESET = 1'b1; mfa = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    checks++;
    if (moc !== 1'b0) begin errors++; $display("FAIL midreset_moc got %b want 0", moc); end
    rd("midreset_mem", 1'b0, SZ_W, 32'h40, 32'h0BADF00D);
  endtask

  task automatic test_top_addr_ws0;
    wr(1'b1, SZ_B, 32'h00, 32'h3C);
    wr(1'b1, SZ_W, 32'hFF, 32'hA5A5A5A5);
    for (int i = 0; i < 4; i++) rd("top_byte", 1'b1, SZ_B, 32'hFC + i, 32'hA5);
    rd("top_word", 1'b1, SZ_SH, 32'hFE, 32'hFFFFA5A5);
    rd("zero_untouched", 1'b1, SZ_B, 32'h00, 32'h3C);
  endtask

  initial begin
    test_reset;
    test_word_be;
    test_subword;
    test_handshake_hold;
    test_abort;
    test_mid_reset;
    test_top_addr_ws0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
